// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS32-subset core.
// Holds the opcode/funct encodings of the supported instructions, the ALU
// operation and core state enumerations, and a helper that assembles a
// big-endian store word from its bytes (byte 0 lands in bits [31:24]).
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_SLT     = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } core_state_e;

    function automatic logic [31:0] be_pack(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] b2, input logic [7:0] b3);
        return {b0, b1, b2, b3};
    endfunction

endpackage

// File: rtl/mips_mc_regfile.sv
// 32 x 32-bit register file for the multi-cycle core.
// Ports:
//   clk, rst        clock and asynchronous active-high clear of all registers
//   ra1, ra2 / rd1, rd2   two asynchronous read ports ($0 always reads 0)
//   we, wa, wd      synchronous write port (writes to $0 are dropped)
module mips_mc_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);

    logic [31:0] regs_q [32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (wa != 5'd0)) begin
            regs_q[wa] <= wd;
        end
    end

    // $0 is hard-wired so the array entry never matters.
    assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs_q[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs_q[ra2];

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS32-subset core sharing one memory port for fetch and data.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   mem_req/we/addr/wdata   request to memory, held stable until mem_ready
//   mem_rdata, mem_ready    memory response (rdata valid when ready=1)
//   pc            address of the instruction in flight
//   retire        one-cycle pulse as an instruction completes
//   halted, trap  sticky status: halted by syscall/trap, trap on illegal/misaligned
module mips_multicycle_core
    import mips_pkg::*;
#(
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter bit          TRAP_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              retire,
    output logic              halted,
    output logic              trap
);

    core_state_e       state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d, a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
    logic              halted_q, halted_d, trap_q, trap_d;

    logic [5:0]        opcode, funct;
    logic [4:0]        rs, rt, rd;
    logic [31:0]       imm_sext, alu_b, alu_y, rf_rd1, rf_rd2, rf_wd, jump_full;
    logic [ADDR_W-1:0] pc_plus4, branch_target, jump_target;
    logic [4:0]        rf_wa;
    logic              rf_we, is_legal, taken, req_c;
    alu_op_e           alu_op;

    assign opcode   = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign funct    = ir_q[5:0];
    assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};

    // pc_q stays on the current instruction, so both branch and jump targets
    // are formed from pc+4; the jump keeps the top nibble of pc+4 and any
    // bits above ADDR_W are dropped by the final truncation.
    assign pc_plus4      = pc_q + ADDR_W'(32'd4);
    assign branch_target = pc_plus4 + ADDR_W'({imm_sext[29:0], 2'b00});
    assign jump_full     = (32'(pc_plus4) & 32'hF000_0000) | {4'b0000, ir_q[25:0], 2'b00};
    assign jump_target   = ADDR_W'(jump_full);
    assign taken         = (a_q == b_q) ^ (opcode == OP_BNE);

    mips_mc_regfile u_regfile (
        .clk (clk),
        .rst (rst),
        .ra1 (rs),
        .ra2 (rt),
        .rd1 (rf_rd1),
        .rd2 (rf_rd2),
        .we  (rf_we),
        .wa  (rf_wa),
        .wd  (rf_wd)
    );

    // Recognise the supported instruction set; anything else is illegal.
    always_comb begin
        is_legal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SYSCALL: is_legal = 1'b1;
                    default:                                           is_legal = 1'b0;
                endcase
            end
            OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: is_legal = 1'b1;
            default:                                     is_legal = 1'b0;
        endcase
    end

    // ALU: R-type selects by funct against B, everything else adds the immediate.
    always_comb begin
        alu_op = ALU_ADD;
        alu_b  = imm_sext;
        if (opcode == OP_RTYPE) begin
            alu_b = b_q;
            case (funct)
                FN_SUB:  alu_op = ALU_SUB;
                FN_AND:  alu_op = ALU_AND;
                FN_OR:   alu_op = ALU_OR;
                FN_SLT:  alu_op = ALU_SLT;
                default: alu_op = ALU_ADD;
            endcase
        end
        case (alu_op)
            ALU_SUB: alu_y = a_q - alu_b;
            ALU_AND: alu_y = a_q & alu_b;
            ALU_OR:  alu_y = a_q | alu_b;
            ALU_SLT: alu_y = {31'd0, $signed(a_q) < $signed(alu_b)};
            default: alu_y = a_q + alu_b;
        endcase
    end

    // Sequencing: next-state, datapath register loads and memory port drive.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_d     = alu_q;
        mdr_d     = mdr_q;
        halted_d  = halted_q;
        trap_d    = trap_q;
        req_c     = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc_q;
        mem_wdata = 32'd0;
        retire    = 1'b0;
        rf_we     = 1'b0;
        rf_wa     = rd;
        rf_wd     = alu_q;
        case (state_q)
            ST_FETCH: begin
                req_c = 1'b1;
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                a_d = rf_rd1;
                b_d = rf_rd2;
                if (!is_legal && TRAP_EN) begin
                    halted_d = 1'b1;
                    trap_d   = 1'b1;
                    state_d  = ST_HALT;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Illegal opcodes only get here with traps disabled: retire as a nop.
                if (!is_legal) begin
                    retire  = 1'b1;
                    pc_d    = pc_plus4;
                    state_d = ST_FETCH;
                end else begin
                    case (opcode)
                        OP_RTYPE: begin
                            if (funct == FN_SYSCALL) begin
                                halted_d = 1'b1;
                                state_d  = ST_HALT;
                            end else begin
                                alu_d   = alu_y;
                                state_d = ST_WB;
                            end
                        end
                        OP_LW, OP_SW: begin
                            alu_d = alu_y;
                            if (alu_y[1:0] == 2'b00) begin
                                state_d = ST_MEM;
                            end else if (TRAP_EN) begin
                                halted_d = 1'b1;
                                trap_d   = 1'b1;
                                state_d  = ST_HALT;
                            end else begin
                                retire  = 1'b1;
                                pc_d    = pc_plus4;
                                state_d = ST_FETCH;
                            end
                        end
                        OP_BEQ, OP_BNE: begin
                            retire  = 1'b1;
                            pc_d    = taken ? branch_target : pc_plus4;
                            state_d = ST_FETCH;
                        end
                        OP_J: begin
                            retire  = 1'b1;
                            pc_d    = jump_target;
                            state_d = ST_FETCH;
                        end
                        default: begin
                            alu_d   = alu_y;
                            state_d = ST_WB;
                        end
                    endcase
                end
            end
            ST_MEM: begin
                req_c    = 1'b1;
                mem_addr = ADDR_W'(alu_q);
                if (opcode == OP_SW) begin
                    mem_we    = 1'b1;
                    mem_wdata = be_pack(b_q[31:24], b_q[23:16], b_q[15:8], b_q[7:0]);
                end
                if (mem_ready) begin
                    if (opcode == OP_SW) begin
                        retire  = 1'b1;
                        pc_d    = pc_plus4;
                        state_d = ST_FETCH;
                    end else begin
                        mdr_d   = mem_rdata;
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                rf_we = 1'b1;
                if (opcode != OP_RTYPE) begin
                    rf_wa = rt;
                    rf_wd = (opcode == OP_LW) ? mdr_q : alu_q;
                end
                retire  = 1'b1;
                pc_d    = pc_plus4;
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_FETCH;
            pc_q     <= ADDR_W'(RESET_PC);
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            alu_q    <= '0;
            mdr_q    <= '0;
            halted_q <= 1'b0;
            trap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            alu_q    <= alu_d;
            mdr_q    <= mdr_d;
            halted_q <= halted_d;
            trap_q   <= trap_d;
        end
    end

    // Reset parks the FSM in FETCH, so the request is masked while rst is high
    // to drop it immediately and abandon any pending store.
    assign mem_req = req_c & ~rst;
    assign pc      = pc_q;
    assign halted  = halted_q;
    assign trap    = trap_q;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Self-checking bench for mips_multicycle_core: a variable-latency memory
// model, a table of ALU vectors, and directed multi-cycle sequences.
module tb_mips_multicycle_core;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [5:0]  TB_J = 6'h02, TB_BEQ = 6'h04, TB_BNE = 6'h05, TB_ADDI = 6'h08;
    localparam logic [5:0]  TB_LW = 6'h23, TB_SW = 6'h2B;
    localparam logic [5:0]  TB_ADD = 6'h20, TB_SUB = 6'h22, TB_AND = 6'h24, TB_OR = 6'h25;
    localparam logic [5:0]  TB_SLT = 6'h2A;
    localparam logic [31:0] TB_SYSCALL = 32'h0000_000C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_we, mem_ready, retire, halted, trap;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;

    int testsRun = 0;
    int testsFailed = 0;

    // Memory model state
    logic [31:0] progImg [256];
    logic [31:0] mem [256];
    int          latency = 0;
    int          waitCnt = 0;
    int          waitCycles = 0;
    int          stableErr = 0;
    int          retireCnt = 0;
    logic        holdValid = 1'b0;
    logic        holdWe;
    logic [31:0] holdAddr, holdWdata;
    logic [31:0] readLog[$];
    logic [31:0] writeAddrQ[$];
    logic [31:0] writeDataQ[$];

    always #5 clk = ~clk;

    mips_multicycle_core #(
        .ADDR_W   (32),
        .RESET_PC (RESET_PC),
        .TRAP_EN  (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .pc        (pc),
        .retire    (retire),
        .halted    (halted),
        .trap      (trap)
    );

    // Memory answers after `latency` wait cycles; rdata is combinational.
    assign mem_ready = mem_req && (waitCnt >= latency);
    assign mem_rdata = mem[mem_addr[9:2]];

    // Memory model: loads the program image during reset, completes requests,
    // logs accesses and flags any request field that moves while waiting.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] = progImg[i];
            waitCnt    <= 0;
            waitCycles <= 0;
            stableErr  <= 0;
            holdValid  <= 1'b0;
            readLog.delete();
            writeAddrQ.delete();
            writeDataQ.delete();
        end else if (mem_req) begin
            if (holdValid && (mem_addr !== holdAddr || mem_we !== holdWe || mem_wdata !== holdWdata))
                stableErr <= stableErr + 1;
            if (mem_ready) begin
                if (mem_we) begin
                    mem[mem_addr[9:2]] = mem_wdata;
                    writeAddrQ.push_back(mem_addr);
                    writeDataQ.push_back(mem_wdata);
                end else begin
                    readLog.push_back(mem_addr);
                end
                waitCnt   <= 0;
                holdValid <= 1'b0;
            end else begin
                waitCnt    <= waitCnt + 1;
                waitCycles <= waitCycles + 1;
                holdValid  <= 1'b1;
                holdAddr   <= mem_addr;
                holdWe     <= mem_we;
                holdWdata  <= mem_wdata;
            end
        end else begin
            waitCnt   <= 0;
            holdValid <= 1'b0;
        end
    end

    // Count retire pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) retireCnt <= 0;
        else if (retire) retireCnt <= retireCnt + 1;
    end

    function automatic logic [31:0] rEnc(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] iEnc(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic clearProg();
        for (int i = 0; i < 256; i++) progImg[i] = 32'd0;
    endtask

    task automatic applyStimulus(input int lat);
        latency = lat;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic runUntilHalt(input string name, input int budget);
        int cyc = 0;
        while (!halted && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        #1;
        checkOutput({name, " halted"}, {31'd0, halted}, 32'd1);
    endtask

    typedef struct {
        string       name;
        logic [31:0] aVal;
        logic [31:0] bVal;
        logic [31:0] opInstr;
        logic [4:0]  dst;
        logic [31:0] expVal;
    } aluVec_t;

    aluVec_t vecs[10];
    logic [31:0] expFetch[9];

    initial begin
        vecs[0] = '{"add wrap",  32'hFFFF_FFFF, 32'h2,         rEnc(1, 2, 3, TB_ADD), 5'd3, 32'h1};
        vecs[1] = '{"sub neg",   32'h5,         32'h7,         rEnc(1, 2, 3, TB_SUB), 5'd3, 32'hFFFF_FFFE};
        vecs[2] = '{"and",       32'hF0F0_1234, 32'h0FF0_FF00, rEnc(1, 2, 4, TB_AND), 5'd4, 32'h00F0_1200};
        vecs[3] = '{"or",        32'hF000_0001, 32'h0000_0F10, rEnc(1, 2, 5, TB_OR),  5'd5, 32'hF000_0F11};
        vecs[4] = '{"slt signed", 32'hFFFF_FFFF, 32'h1,        rEnc(1, 2, 6, TB_SLT), 5'd6, 32'h1};
        vecs[5] = '{"slt false", 32'h5,         32'h8000_0000, rEnc(1, 2, 6, TB_SLT), 5'd6, 32'h0};
        vecs[6] = '{"slt equal", 32'h7,         32'h7,         rEnc(1, 2, 7, TB_SLT), 5'd7, 32'h0};
        vecs[7] = '{"write r0",  32'h3,         32'h4,         rEnc(1, 2, 0, TB_ADD), 5'd0, 32'h0};
        vecs[8] = '{"addi neg",  32'h0,         32'h9,         iEnc(TB_ADDI, 1, 3, 16'hFFFF), 5'd3, 32'hFFFF_FFFF};
        vecs[9] = '{"sub wrap",  32'h8000_0000, 32'h1,         rEnc(1, 2, 3, TB_SUB), 5'd3, 32'h7FFF_FFFF};

        clearProg();

        // Reset values while rst is held
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst mem_req",   {31'd0, mem_req}, 32'd0);
        checkOutput("rst mem_we",    {31'd0, mem_we},  32'd0);
        checkOutput("rst retire",    {31'd0, retire},  32'd0);
        checkOutput("rst halted",    {31'd0, halted},  32'd0);
        checkOutput("rst trap",      {31'd0, trap},    32'd0);
        checkOutput("rst mem_addr",  mem_addr,         RESET_PC);
        checkOutput("rst mem_wdata", mem_wdata,        32'd0);
        checkOutput("rst pc",        pc,               RESET_PC);

        // T2: dependent ALU chain, cycle count to the 4th retire, results via sw
        clearProg();
        progImg[0] = iEnc(TB_ADDI, 0, 1, 16'd5);
        progImg[1] = iEnc(TB_ADDI, 0, 2, 16'hFFFD);
        progImg[2] = rEnc(1, 2, 3, TB_ADD);
        progImg[3] = rEnc(2, 1, 4, TB_SLT);
        progImg[4] = iEnc(TB_SW, 0, 3, 16'h0200);
        progImg[5] = iEnc(TB_SW, 0, 4, 16'h0204);
        progImg[6] = TB_SYSCALL;
        applyStimulus(0);
        begin
            int cyc = 1;
            int ret = 0;
            while (ret < 4 && cyc < 64) begin
                @(negedge clk);
                cyc++;
                if (retire) ret++;
            end
            checkOutput("T2 cycles to 4 retires", cyc, 32'd16);
        end
        runUntilHalt("T2", 200);
        checkOutput("T2 $3", mem[128], 32'd2);
        checkOutput("T2 $4", mem[129], 32'd1);
        checkOutput("T2 retires", retireCnt, 32'd6);
        checkOutput("T2 trap", {31'd0, trap}, 32'd0);

        // T1: reset during a stalled fetch at pc 8
        applyStimulus(0);
        repeat (8) @(negedge clk);
        latency = 1000;
        repeat (2) @(negedge clk);
        checkOutput("T1 stalled req",  {31'd0, mem_req}, 32'd1);
        checkOutput("T1 stalled addr", mem_addr, 32'h8);
        rst = 1'b1;
        #1;
        checkOutput("T1 req drops on rst", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("T1 req after release",  {31'd0, mem_req}, 32'd1);
        checkOutput("T1 addr after release", mem_addr, RESET_PC);

        // Table-driven ALU vectors, operands loaded from memory, result stored back
        for (int i = 0; i < 10; i++) begin
            clearProg();
            progImg[0]   = iEnc(TB_LW, 0, 1, 16'h0200);
            progImg[1]   = iEnc(TB_LW, 0, 2, 16'h0204);
            progImg[2]   = vecs[i].opInstr;
            progImg[3]   = iEnc(TB_SW, 0, vecs[i].dst, 16'h0208);
            progImg[4]   = TB_SYSCALL;
            progImg[128] = vecs[i].aVal;
            progImg[129] = vecs[i].bVal;
            progImg[130] = 32'hDEAD_BEEF;
            applyStimulus(i % 3);
            runUntilHalt(vecs[i].name, 300);
            checkOutput({vecs[i].name, " result"}, mem[130], vecs[i].expVal);
            checkOutput({vecs[i].name, " retires"}, retireCnt, 32'd4);
        end

        // T3: sw then lw under 3-cycle memory latency
        clearProg();
        progImg[0]  = {TB_J, 26'h40};
        progImg[64] = iEnc(TB_ADDI, 0, 3, 16'd2);
        progImg[65] = iEnc(TB_SW, 0, 3, 16'h0008);
        progImg[66] = iEnc(TB_LW, 0, 5, 16'h0008);
        progImg[67] = iEnc(TB_SW, 0, 5, 16'h0200);
        progImg[68] = TB_SYSCALL;
        applyStimulus(3);
        runUntilHalt("T3", 400);
        checkOutput("T3 first store addr", (writeAddrQ.size() > 0) ? writeAddrQ[0] : 32'hFFFF_FFFF, 32'h8);
        checkOutput("T3 first store data", (writeDataQ.size() > 0) ? writeDataQ[0] : 32'hFFFF_FFFF, 32'h2);
        checkOutput("T3 $5", mem[128], 32'd2);
        checkOutput("T3 request stable over wait", stableErr, 32'd0);
        checkOutput("T3 wait cycles seen", {31'd0, waitCycles > 0}, 32'd1);
        checkOutput("T3 retires", retireCnt, 32'd5);

        // T4: taken beq, untaken bne, jump
        clearProg();
        for (int i = 0; i < 4; i++) progImg[i] = iEnc(TB_ADDI, 0, 5'(i + 1), 16'd7);
        progImg[4]  = iEnc(TB_BEQ, 0, 0, 16'd2);
        progImg[5]  = iEnc(TB_ADDI, 0, 8, 16'h55);
        progImg[6]  = iEnc(TB_ADDI, 0, 8, 16'h55);
        progImg[7]  = iEnc(TB_BNE, 0, 0, 16'd2);
        progImg[8]  = {TB_J, 26'h40};
        progImg[64] = iEnc(TB_SW, 0, 8, 16'h0200);
        progImg[65] = TB_SYSCALL;
        progImg[128] = 32'hDEAD_BEEF;
        expFetch = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h1C, 32'h20, 32'h100, 32'h104};
        applyStimulus(1);
        runUntilHalt("T4", 400);
        checkOutput("T4 fetch count", readLog.size(), 32'd9);
        for (int i = 0; i < 9; i++) begin
            if (i < readLog.size())
                checkOutput($sformatf("T4 fetch %0d", i), readLog[i], expFetch[i]);
        end
        checkOutput("T4 skipped $8", mem[128], 32'd0);
        checkOutput("T4 retires", retireCnt, 32'd8);

        // T5: misaligned lw traps before any data access
        clearProg();
        progImg[0] = iEnc(TB_ADDI, 0, 1, 16'd7);
        progImg[1] = iEnc(TB_LW, 0, 1, 16'd2);
        applyStimulus(0);
        runUntilHalt("T5", 100);
        checkOutput("T5 trap", {31'd0, trap}, 32'd1);
        checkOutput("T5 accesses", readLog.size() + writeAddrQ.size(), 32'd2);
        checkOutput("T5 $1 unchanged", dut.u_regfile.regs_q[1], 32'd7);
        checkOutput("T5 retires", retireCnt, 32'd1);

        // Illegal opcode traps from DECODE
        clearProg();
        progImg[0] = 32'hFC00_0000;
        applyStimulus(0);
        runUntilHalt("illegal", 100);
        checkOutput("illegal trap", {31'd0, trap}, 32'd1);
        checkOutput("illegal accesses", readLog.size(), 32'd1);

        // T6: syscall halts without trap, stays quiet, reset clears it
        clearProg();
        progImg[0] = TB_SYSCALL;
        applyStimulus(0);
        runUntilHalt("T6", 100);
        checkOutput("T6 trap", {31'd0, trap}, 32'd0);
        begin
            int reqSeen = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (mem_req) reqSeen++;
            end
            checkOutput("T6 mem_req quiet", reqSeen, 32'd0);
        end
        checkOutput("T6 retires", retireCnt, 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("T6 rst clears halted", {31'd0, halted}, 32'd0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
